// File: rtl/master_port.sv
// Serial-bus initiator: turns one parallel core request into the bus handshake,
// shifts address/data/descriptor out LSB first and collects serial read beats.
module master_port #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [CNT_W-1:0]  burst_len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] rdata_out,
  output logic              rdata_valid,
  output logic              read_en,
  output logic              write_en,
  output logic              master_valid,
  output logic              master_ready,
  input  logic              slave_ready,
  input  logic              slave_valid,
  input  logic              split_en,
  output logic              tx_address,
  output logic              tx_data,
  output logic              tx_burst,
  input  logic              rx_data
);

  typedef enum logic [2:0] {IDLE, REQ, SHIFT, WR_END, RD_WAIT, SPLIT, RX, GAP} state_t;

  localparam int BW = $clog2(CNT_W + 2);
  localparam int RW = $clog2(DATA_W) + 1;
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] TMO_MAX  = '1;

  state_t             state, state_d;
  logic [ADDR_W-1:0]  addr_sr, addr_d;
  logic [DATA_W-1:0]  data_sr, data_d;
  logic [CNT_W:0]     desc_sr, desc_d;
  logic [BW-1:0]      bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0]  rx_sr, rx_d;
  logic [RW-1:0]      rx_cnt, rx_cnt_d;
  logic [CNT_W:0]     beats_left, beats_d;
  logic [TW-1:0]      tmo_cnt, tmo_d;
  logic               wr_q, wr_d;
  logic               busy_d, done_d, error_d, rdata_valid_d;
  logic               read_en_d, write_en_d, mv_d, mr_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               tmo_hit, waiting;
  logic [DATA_W-1:0]  rx_next;

  // Serial lines only carry shift-register bits while the request phase is live.
  assign tx_address = (state == REQ || state == SHIFT) ? addr_sr[0] : 1'b0;
  assign tx_data    = (state == REQ || state == SHIFT) ? data_sr[0] : 1'b0;
  assign tx_burst   = (state == REQ || state == SHIFT) ? desc_sr[0] : 1'b0;

  assign rx_next = {rx_data, rx_sr[DATA_W-1:1]};
  assign waiting = (state == REQ) || (state == WR_END) || (state == RD_WAIT) || (state == SPLIT);
  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  always_comb begin
    state_d       = state;
    addr_d        = addr_sr;
    data_d        = data_sr;
    desc_d        = desc_sr;
    bit_cnt_d     = bit_cnt;
    rx_d          = rx_sr;
    rx_cnt_d      = rx_cnt;
    beats_d       = beats_left;
    wr_d          = wr_q;
    busy_d        = busy;
    done_d        = 1'b0;
    error_d       = 1'b0;
    rdata_valid_d = 1'b0;
    rdata_d       = rdata_out;
    read_en_d     = read_en;
    write_en_d    = write_en;
    mv_d          = master_valid;
    mr_d          = master_ready;
    case (state)
      IDLE: if (start) begin
        addr_d     = addr_in;
        data_d     = wr ? wdata_in : '0;
        desc_d     = wr ? '0 : {burst_len, (burst_len != '0)};
        beats_d    = {1'b0, burst_len} + (CNT_W+1)'(1);
        wr_d       = wr;
        busy_d     = 1'b1;
        read_en_d  = ~wr;
        write_en_d = wr;
        mv_d       = 1'b1;
        state_d    = REQ;
      end
      REQ: if (slave_ready) begin
        addr_d    = addr_sr >> 1;
        data_d    = data_sr >> 1;
        desc_d    = desc_sr >> 1;
        bit_cnt_d = BW'(1);
        state_d   = SHIFT;
      end
      SHIFT: begin
        addr_d    = addr_sr >> 1;
        data_d    = data_sr >> 1;
        desc_d    = desc_sr >> 1;
        bit_cnt_d = bit_cnt + BW'(1);
        if (bit_cnt == BW'(CNT_W)) begin
          bit_cnt_d = '0;
          mv_d      = 1'b0;
          if (wr_q) state_d = WR_END;
          else begin
            mr_d    = 1'b1;
            state_d = RD_WAIT;
          end
        end
      end
      WR_END: if (slave_ready) begin
        write_en_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      RD_WAIT, SPLIT: begin
        // slave_valid has priority over a split request arriving in the same cycle
        if (slave_valid) begin
          rx_d     = rx_next;
          rx_cnt_d = RW'(1);
          state_d  = RX;
        end else if (split_en && state == RD_WAIT) begin
          state_d  = SPLIT;
        end
      end
      RX: begin
        rx_d     = rx_next;
        rx_cnt_d = rx_cnt + RW'(1);
        if (rx_cnt == RW'(DATA_W - 1)) begin
          rx_cnt_d      = '0;
          rdata_d       = rx_next;
          rdata_valid_d = 1'b1;
          beats_d       = (beats_left != '0) ? beats_left - (CNT_W+1)'(1) : '0;
          mr_d          = 1'b0;
          if (beats_left <= (CNT_W+1)'(1)) begin
            read_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        mr_d    = 1'b1;
        state_d = RD_WAIT;
      end
      default: state_d = IDLE;
    endcase

    // Abort only when the wait state did not make progress this cycle.
    if (waiting && state_d == state && tmo_hit) begin
      busy_d     = 1'b0;
      read_en_d  = 1'b0;
      write_en_d = 1'b0;
      mv_d       = 1'b0;
      mr_d       = 1'b0;
      error_d    = 1'b1;
      state_d    = IDLE;
    end

    if (!waiting || state_d != state) tmo_d = '0;
    else tmo_d = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      addr_sr      <= '0;
      data_sr      <= '0;
      desc_sr      <= '0;
      bit_cnt      <= '0;
      rx_sr        <= '0;
      rx_cnt       <= '0;
      beats_left   <= '0;
      tmo_cnt      <= '0;
      wr_q         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      rdata_out    <= '0;
      rdata_valid  <= 1'b0;
      read_en      <= 1'b0;
      write_en     <= 1'b0;
      master_valid <= 1'b0;
      master_ready <= 1'b0;
    end else begin
      state        <= state_d;
      addr_sr      <= addr_d;
      data_sr      <= data_d;
      desc_sr      <= desc_d;
      bit_cnt      <= bit_cnt_d;
      rx_sr        <= rx_d;
      rx_cnt       <= rx_cnt_d;
      beats_left   <= beats_d;
      tmo_cnt      <= tmo_d;
      wr_q         <= wr_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      rdata_out    <= rdata_d;
      rdata_valid  <= rdata_valid_d;
      read_en      <= read_en_d;
      write_en     <= write_en_d;
      master_valid <= mv_d;
      master_ready <= mr_d;
    end
  end

endmodule
